// File: rtl/ultrasonic_proximity_if.sv
// Signal bundle between the ranging front end and the two ultrasonic sensors.
// The ranging controller is the master; the sensor pair (or a bench) is the slave.
interface ultrasonic_proximity_if;
   logic echo_left;
   logic echo_right;
   logic trig_left;
   logic trig_right;
   logic sensor_left;
   logic sensor_right;
   logic meas_valid;

   modport master (
      input  echo_left, echo_right,
      output trig_left, trig_right, sensor_left, sensor_right, meas_valid
   );

   modport slave (
      output echo_left, echo_right,
      input  trig_left, trig_right, sensor_left, sensor_right, meas_valid
   );
endinterface

// File: rtl/ultrasonic_proximity.sv
// Alternating two-sensor ultrasonic ranging with echo-width timing and
// per-side confirmation filtering of the registered proximity flags.
module ultrasonic_proximity #(
   parameter int TRIG_CYCLES  = 1000,
   parameter int GAP_CYCLES   = 6_000_000,
   parameter int ECHO_TIMEOUT = 3_800_000,
   parameter int CLOSE_CYCLES = 174_000,
   parameter int CONFIRM      = 2,
   parameter int CNT_W        = 23
) (
   input logic                   clk,
   input logic                   reset,
   ultrasonic_proximity_if.master bus
);
   typedef enum logic [2:0] {GAP, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CLOSE_LIM    = CNT_W'(CLOSE_CYCLES);
   localparam logic [2:0]       CONF_LIM     = 3'(CONFIRM);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, width;
   logic             echo_left_p0, echo_left_p1, echo_right_p0, echo_right_p1;
   logic             echo_act, echo_prev, side;
   logic             finish, close_raw, cnt_clr;
   logic             flag_left, flag_right;
   logic [2:0]       conf_left, conf_right;

   // Returns {flag, confirm count} after folding in one raw result.
   function automatic logic [3:0] confirm_step(input logic raw, input logic flag,
                                               input logic [2:0] conf);
      logic [2:0] inc;
      inc = conf + 3'd1;
      if (raw == flag) return {flag, 3'd0};
      if (inc == CONF_LIM) return {~flag, 3'd0};
      return {flag, inc};
   endfunction

   // Only the active side's synchronized echo reaches the measurement logic.
   assign echo_act = side ? echo_right_p1 : echo_left_p1;

   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      close_raw = 1'b0;
      case (state)
         GAP:       if (cnt == GAP_LAST) state_nxt = TRIG;
         TRIG:      if (cnt == TRIG_LAST) state_nxt = WAIT_ECHO;
         WAIT_ECHO: begin
            if (cnt == TIMEOUT_LAST) begin
               state_nxt = DONE;
               finish    = 1'b1;
            end else if (echo_act && !echo_prev) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            if (cnt == TIMEOUT_LAST) begin
               state_nxt = DONE;
               finish    = 1'b1;
            end else if (!echo_act) begin
               state_nxt = DONE;
               finish    = 1'b1;
               close_raw = (width < CLOSE_LIM);
            end
         end
         DONE:      state_nxt = GAP;
         default:   state_nxt = GAP;
      endcase
      // The timeout count spans WAIT_ECHO and MEASURE, so that hop keeps it.
      cnt_clr = (state_nxt != state) && !(state == WAIT_ECHO && state_nxt == MEASURE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         echo_left_p0  <= 1'b0;
         echo_left_p1  <= 1'b0;
         echo_right_p0 <= 1'b0;
         echo_right_p1 <= 1'b0;
         echo_prev     <= 1'b0;
         state         <= GAP;
         cnt           <= '0;
         width         <= '0;
         side          <= 1'b0;
         flag_left     <= 1'b0;
         flag_right    <= 1'b0;
         conf_left     <= 3'd0;
         conf_right    <= 3'd0;
      end else begin
         // Stage p0/p1: two-flop synchronizers on both raw echoes.
         echo_left_p0  <= bus.echo_left;
         echo_left_p1  <= echo_left_p0;
         echo_right_p0 <= bus.echo_right;
         echo_right_p1 <= echo_right_p0;
         echo_prev     <= echo_act;
         state         <= state_nxt;
         cnt           <= cnt_clr ? '0 : cnt + 1'b1;
         // The rising-edge cycle in WAIT_ECHO is already one high cycle.
         if (state == WAIT_ECHO)
            width <= CNT_W'(1);
         else if (state == MEASURE && echo_act)
            width <= width + 1'b1;
         if (finish) begin
            if (side)
               {flag_right, conf_right} <= confirm_step(close_raw, flag_right, conf_right);
            else
               {flag_left, conf_left} <= confirm_step(close_raw, flag_left, conf_left);
         end
         if (state == DONE) side <= ~side;
      end
   end

   assign bus.trig_left    = (state == TRIG) && !side;
   assign bus.trig_right   = (state == TRIG) && side;
   assign bus.sensor_left  = flag_left;
   assign bus.sensor_right = flag_right;
   assign bus.meas_valid   = (state == DONE);
endmodule

// File: doc/ultrasonic_proximity.md
# ultrasonic_proximity

Front-end ranging stage that drives two ultrasonic rangefinders (left, right) and produces the registered 1-bit proximity flags `sensor_left` / `sensor_right` consumed by the obstacle-detection stage. It fires the two sensors alternately to avoid acoustic crosstalk and times each echo pulse in clock cycles. Each flag changes only after consecutive agreeing measurements, and "close" means an echo shorter than a programmable threshold.

## Interface
- `TRIG_CYCLES`, 1000: trigger pulse width in clocks (10 µs @ 100 MHz).
- `GAP_CYCLES`, 6_000_000: idle settling time before each trigger (60 ms).
- `ECHO_TIMEOUT`, 3_800_000: max clocks from echo-wait entry to echo end; exceeding it means far.
- `CLOSE_CYCLES`, 174_000: echo width strictly below this means close (~30 cm).
- `CONFIRM`, 2: consecutive agreeing measurements required to change a flag (1..7).
- `CNT_W`, 23: counter width; must hold max(GAP_CYCLES, ECHO_TIMEOUT).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `echo_left` in 1: left sensor echo, asynchronous to `clk`.
- `echo_right` in 1: right sensor echo, asynchronous to `clk`.
- `trig_left` out 1: left trigger pulse.
- `trig_right` out 1: right trigger pulse.
- `sensor_left` out 1: left close flag, 1 = obstacle within threshold.
- `sensor_right` out 1: right close flag.
- `meas_valid` out 1: one-cycle pulse when a measurement completes.

## Operation
- Each echo input passes through its own 2-flop synchronizer. All logic uses only the synchronized echo of the active side; the inactive side's echo is ignored.
- One shared FSM and counter. A side register selects the active sensor.
- GAP state:
  - Counts GAP_CYCLES clocks, then enters TRIG.
  - Counter clears on every state change.
- TRIG state:
  - The active `trig_*` is high for exactly TRIG_CYCLES clocks, then the FSM enters WAIT_ECHO.
  - Both triggers are never high together.
- WAIT_ECHO state:
  - Waits for a low-to-high transition of the synchronized echo.
  - An echo already high on entry is ignored until it falls and rises again.
  - The timeout counter starts at entry and continues through MEASURE.
- MEASURE state:
  - A width counter increments each cycle the echo is high.
  - Exits on the echo falling edge.
  - If the timeout counter reaches ECHO_TIMEOUT in WAIT_ECHO or MEASURE, exit with result = far.
- DONE state (1 cycle):
  - `meas_valid` = 1.
  - Raw result close ⇔ falling edge seen and width < CLOSE_CYCLES. A width equal to CLOSE_CYCLES is far.
  - Update the side's confirm counter:
    - If the raw result equals the current flag, clear the counter.
    - Otherwise increment it. On reaching CONFIRM, toggle the flag and clear the counter.
  - Toggle the side, then go to GAP.
- Sequence after reset: left, right, left, …
- Reset (async):
  - `trig_left`, `trig_right`, `sensor_left`, `sensor_right`, `meas_valid` = 0.
  - FSM = GAP, counters = 0, side = left, confirm counters = 0, synchronizers = 0.
- Reset mid-measurement: the trigger drops immediately and the partial measurement is discarded. The flags read 0 (far) so downstream buzzers go silent.

## Timing
- Echo-to-logic latency: 2 clocks (synchronizer).
- First `trig_left` rise: GAP_CYCLES clock edges after reset deassertion.
- Trigger width: exactly TRIG_CYCLES clocks.
- Measured width: equals the echo high time in clocks (±1 for async sampling).
- Flag/`meas_valid` update:
  - `meas_valid` pulses and the flag updates on the same edge.
  - That edge is 1 clock after the synchronized falling edge is detected, i.e. 3 clocks after the raw echo falls.
  - On timeout, the update comes 1 clock after the timeout count is reached.
- Flags are registered, glitch-free, and change only in DONE.
- Measurement period per side: 2 × (GAP_CYCLES + TRIG_CYCLES + echo/timeout time + 1).

## Test plan
Parameters for all scenarios: TRIG_CYCLES=4, GAP_CYCLES=20, ECHO_TIMEOUT=200, CLOSE_CYCLES=50, CONFIRM=2.
- **Reset values:** assert reset mid-TRIG → `trig_left`=0 asynchronously, all outputs 0. Release → `trig_left` rises after 20 edges and is high 4 clocks.
- **Close confirmation:** left echo 30 clocks, twice → `sensor_left` stays 0 after the first measurement and goes 1 at the second left DONE. Expect 2 `meas_valid` pulses per left/right round.
- **Threshold boundary:** left echo 49 clocks ×2 → `sensor_left`=1. Then left echo exactly 50 clocks ×2 → `sensor_left` returns to 0.
- **Timeout:** with `sensor_right`=1, hold `echo_right` low → a timeout DONE is reached 200 clocks after WAIT_ECHO entry. Two timeouts → `sensor_right`=0. Then hold `echo_right` high for 300 clocks → also counts as far.
- **Side isolation and stale echo:**
  - Pulse `echo_right` during a left measurement → no effect.
  - Hold `echo_left` high on WAIT_ECHO entry, drop it, then give a 30-clock pulse → measured as 30, not the stale width.
- **Confirm hysteresis:** left results close, far, close, close with `sensor_left`=0 → the flag rises only after the final pair. The confirm counter clears on the intervening far result.
